// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, 1-bit slice op encodings, sequencer states and opcode decode.
// Revision 1.0
`default_nettype none
package alu_pkg;

  localparam logic [3:0] ALU_AND_C = 4'b0000;
  localparam logic [3:0] ALU_OR_C  = 4'b0001;
  localparam logic [3:0] ALU_ADD_C = 4'b0010;
  localparam logic [3:0] ALU_SUB_C = 4'b0110;
  localparam logic [3:0] ALU_SLT_C = 4'b0111;
  localparam logic [3:0] ALU_NOR_C = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_op(input logic [3:0] opc);
    alu_ctl_t c;
    c = '0;
    c.valid = 1'b1;
    case (opc)
      ALU_AND_C: c.op = OP_AND;
      ALU_OR_C:  c.op = OP_OR;
      ALU_ADD_C: c.op = OP_ADD;
      ALU_SUB_C: begin c.b_inv = 1'b1; c.op = OP_ADD; end
      ALU_SLT_C: begin c.b_inv = 1'b1; c.op = OP_SLT; end
      ALU_NOR_C: begin c.a_inv = 1'b1; c.b_inv = 1'b1; c.op = OP_AND; end
      default:   c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice (AND/OR/ADD/SLT with operand inversion).
// Revision 1.0
`default_nettype none
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_inv,
  input  logic       b_inv,
  input  logic       cin,
  input  logic [1:0] op,
  input  logic       set,
  output logic       result,
  output logic       sum,
  output logic       cout
);

  logic a_eff;
  logic b_eff;

  always_comb begin
    a_eff = a ^ a_inv;
    b_eff = b ^ b_inv;
    sum   = a_eff ^ b_eff ^ cin;
    cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
    case (op)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      default: result = set;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer, one result bit per clock, LSB first.
// Revision 1.0
`default_nettype none
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALU_control_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  state_t           state;
  alu_ctl_t         ctl;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;

  logic             s_result;
  logic             s_sum;
  logic             s_cout;
  logic             last_bit;
  logic             arith;
  logic             ovf_bit;
  logic             set_bit;
  logic [WIDTH-1:0] final_res;

  alu_bit_slice u_slice (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .a_inv  (ctl.a_inv),
    .b_inv  (ctl.b_inv),
    .cin    (carry),
    .op     (ctl.op),
    .set    (1'b0),
    .result (s_result),
    .sum    (s_sum),
    .cout   (s_cout)
  );

  // Final-bit resolution: SLT uses the overflow-corrected sign of A-B.
  always_comb begin
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
    arith     = ctl.valid & ((ctl.op == OP_ADD) | (ctl.op == OP_SLT));
    ovf_bit   = carry ^ s_cout;
    set_bit   = s_sum ^ ovf_bit;
    final_res = '0;
    if (ctl.valid) begin
      if (ctl.op == OP_SLT) final_res = {{(WIDTH-1){1'b0}}, set_bit};
      else                  final_res = {s_result, res_sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ctl        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && ready_o) begin
            a_sh    <= src1_i;
            b_sh    <= src2_i;
            ctl     <= decode_op(ALU_control_i);
            carry   <= decode_op(ALU_control_i).b_inv;
            cnt     <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          carry  <= s_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {s_result, res_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            result_o   <= final_res;
            zero_o     <= (final_res == '0);
            cout_o     <= arith & s_cout;
            overflow_o <= arith & ovf_bit;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed self-checking bench for serial_alu_ctrl (WIDTH=32).
// Revision 1.0
`default_nettype none
module tb_serial_alu_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       opc;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  int n_checks = 0;
  int n_pass   = 0;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .ALU_control_i (opc),
    .src1_i        (src1),
    .src2_i        (src2),
    .ready_o       (ready),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result),
    .zero_o        (zero),
    .cout_o        (cout),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Issue one op; returns the cycle (accept = cycle 0) in which done was seen.
  // inject_at > 0 re-asserts start with different operands during that RUN cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int lat, output int ready_bad);
    lat = 0;
    ready_bad = 0;
    @(negedge clk);
    start = 1'b1; opc = op; src1 = a; src2 = b;
    @(posedge clk);
    #1 start = 1'b0; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == inject_at) begin
        start = 1'b1; opc = 4'b0110; src1 = 32'h0000_0100; src2 = 32'h0000_0001;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
      if (ready) ready_bad++;
    end
    start = 1'b0;
    if (lat == 0) check("done_timeout", 32'd0, 32'd33);
  endtask

  int lat;
  int rbad;
  int done_seen;

  initial begin
    rst = 1'b1; start = 1'b0; opc = 4'b0000; src1 = '0; src2 = '0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD 7 + 5: latency, flags and ready throughout RUN
    run_op(4'b0010, 32'd7, 32'd5, 0, lat, rbad);
    check("add_latency", lat, 32'd33);
    check("add_result", result, 32'd12);
    check("add_flags", {29'd0, zero, cout, overflow}, 32'b000);
    check("add_ready_run", rbad, 32'd0);
    @(negedge clk);
    check("add_done_pulse", {31'd0, done}, 32'd0);
    check("add_ready_back", {31'd0, ready}, 32'd1);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, lat, rbad);
    check("addwrap_result", result, 32'd0);
    check("addwrap_flags", {29'd0, zero, cout, overflow}, 32'b110);

    run_op(4'b0110, 32'h8000_0000, 32'd1, 0, lat, rbad);
    check("sub_result", result, 32'h7FFF_FFFF);
    check("sub_flags", {29'd0, zero, cout, overflow}, 32'b011);

    run_op(4'b0111, 32'hFFFF_FFFD, 32'd2, 0, lat, rbad);
    check("slt_neg_result", result, 32'd1);

    run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 0, lat, rbad);
    check("slt_ovf_result", result, 32'd0);
    check("slt_ovf_flag", {31'd0, overflow}, 32'd1);

    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, rbad);
    check("and_result", result, 32'hF000_F000);

    run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, rbad);
    check("or_result", result, 32'hFFF0_FFF0);

    run_op(4'b1100, 32'd0, 32'd0, 0, lat, rbad);
    check("nor_result", result, 32'hFFFF_FFFF);
    check("nor_flags", {29'd0, zero, cout, overflow}, 32'b000);

    run_op(4'b1111, 32'h1234_5678, 32'h0000_0001, 0, lat, rbad);
    check("badop_latency", lat, 32'd33);
    check("badop_result", result, 32'd0);
    check("badop_flags", {29'd0, zero, cout, overflow}, 32'b100);

    // start during RUN must be ignored
    run_op(4'b0010, 32'd7, 32'd5, 10, lat, rbad);
    check("ignore_latency", lat, 32'd33);
    check("ignore_result", result, 32'd12);
    @(negedge clk);
    @(negedge clk);
    check("ignore_no_queue", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; opc = 4'b0010; src1 = 32'd100; src2 = 32'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    #3 rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("arst_no_done", done_seen, 32'd0);

    run_op(4'b0110, 32'd50, 32'd8, 0, lat, rbad);
    check("post_rst_latency", lat, 32'd33);
    check("post_rst_result", result, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
